wb_select_stage: RTL and testbench
==================================

# wb_select_stage

Registered writeback stage for the pipelined MIPS core. It generalises the combinational writeback data mux in three ways: it latches the MEM/WB pipeline register, it extracts and extends sub-word load data, and it gates the register-file write. It also keeps a retired-instruction counter for the debug unit. It sits between the data memory and the register file's write port.

## Interface
Parameters:
- NBITS, 32, datapath width; must be a multiple of 16, at least 16.
- SELBITS, 2, source-select width; must be at least 2.
- REGBITS, 5, register-address width.
- OFFBITS, $clog2(NBITS/8), byte-offset width.
- CNTBITS, 32, retired-counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_valid  in  1  MEM-stage instruction is valid.
- i_regwrite  in  1  instruction writes the register file.
- i_waddr  in  REGBITS  destination register.
- i_sel_regdata  in  SELBITS  source select: 0 ALU, 1 DATAMEM, 2 LINK, 3 IMM.
- i_aluresult  in  NBITS  ALU result.
- i_data  in  NBITS  raw data-memory word.
- i_link  in  NBITS  return address (PC+8).
- i_imm  in  NBITS  upper-immediate value (LUI).
- i_ld_size  in  2  load size: 00 byte, 01 half, 10 word, 11 word.
- i_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
- i_byte_off  in  OFFBITS  address low bits of the load.
- i_stall  in  1  hold the pipeline register.
- i_flush  in  1  insert a bubble.
- i_cnt_clr  in  1  synchronous clear of the retired counter.
- o_valid  out  1  registered valid.
- o_reg_we  out  1  register-file write enable.
- o_reg_waddr  out  REGBITS  register-file write address.
- o_reg_wdata  out  NBITS  register-file write data.
- o_retired  out  CNTBITS  count of retired instructions.

## Operation
- Source select on the registered fields:
  - 0: ALU result.
  - 1: extracted load data.
  - 2: link.
  - 3: immediate.
  - Any code above 3 (possible only when SELBITS > 2): all-ones data, and o_reg_we is forced to 0.
- Load extraction is little-endian.
  - Byte: lane i_byte_off, bits [8*off+7 : 8*off].
  - Half: offset with bit 0 cleared, bits [8*off+15 : 8*off].
  - Word: offset ignored, full word.
  - Extension to NBITS: sign or zero according to i_ld_unsigned.
  - Extraction applies only when the select is 1. For other selects, size, offset and unsigned are ignored.
- Write gating: o_reg_we = valid & regwrite & (waddr != 0). Writes to register 0 are always suppressed.
- Pipeline register update, each edge, in priority order:
  1. Flush: valid and regwrite clear to 0; other fields don't-care (held).
  2. Stall: all fields hold.
  3. Otherwise: capture all inputs.
- Flush wins over a simultaneous stall.
- Retired counter, each edge, in priority order:
  1. i_cnt_clr: counter loads 0.
  2. A registered valid instruction leaves the stage (o_valid & ~i_stall): counter increments by 1.
- The counter wraps from all-ones to 0 with no saturation.
- A clear that coincides with a retire yields 0.
- Every retired valid instruction counts, whether or not it writes a register.

## Timing
- Latency is 1 cycle from input capture to o_reg_* valid. o_reg_wdata is combinational from the registered fields, so it needs no second cycle.
- Reset (i_rst_n low, asynchronous):
  - o_valid = 0, o_reg_we = 0, o_reg_waddr = 0, o_reg_wdata = 0 (all registered fields cleared, select = 0), o_retired = 0.
- Reset asserted mid-stall or mid-flush overrides both immediately. The first capture happens on the first edge after deassertion.
- Under stall, outputs are stable cycle-to-cycle. o_reg_we stays high when the held instruction writes, so the register file rewrites the same value, which is harmless.
- No handshake back-pressure leaves this block. Stall and flush come from the hazard unit.

## Test plan
- Reset, then ALU select with aluresult=0x12345678, waddr=8, regwrite=1, valid=1 -> next cycle we=1, waddr=8, wdata=0x12345678, retired=1.
- Select 1 with data=0x80FF7F01:
  - byte, off=2, signed -> wdata=0xFFFFFFFF.
  - byte, off=2, unsigned -> 0x000000FF.
  - half, off=3, signed -> 0xFFFF80FF.
  - byte, off=0 -> 0x00000001.
- waddr=0 with regwrite=1, valid=1 -> we=0, and retired still increments.
- Load A, then stall for 3 cycles while presenting B -> outputs hold A for the 3 cycles, and retired does not increment while stalled. Stall+flush in the same cycle -> next cycle valid=0, we=0.
- Select 2 with link=0x00400010 -> wdata=0x00400010. Select 3 with imm=0xABCD0000 -> wdata=0xABCD0000.
- With CNTBITS=4, retire 17 instructions -> retired=1. Assert i_cnt_clr together with a retire -> retired=0. Assert i_rst_n low asynchronously mid-sequence -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/wb_select_stage_if.sv
// Bundles the MEM/WB pipeline inputs and the register-file write outputs
// of the writeback select stage.
interface wb_select_stage_if #(
    parameter int NBITS   = 32,
    parameter int SELBITS = 2,
    parameter int REGBITS = 5,
    parameter int OFFBITS = $clog2(NBITS / 8),
    parameter int CNTBITS = 32
);
    logic               i_valid;
    logic               i_regwrite;
    logic [REGBITS-1:0] i_waddr;
    logic [SELBITS-1:0] i_sel_regdata;
    logic [NBITS-1:0]   i_aluresult;
    logic [NBITS-1:0]   i_data;
    logic [NBITS-1:0]   i_link;
    logic [NBITS-1:0]   i_imm;
    logic [1:0]         i_ld_size;
    logic               i_ld_unsigned;
    logic [OFFBITS-1:0] i_byte_off;
    logic               i_stall;
    logic               i_flush;
    logic               i_cnt_clr;
    logic               o_valid;
    logic               o_reg_we;
    logic [REGBITS-1:0] o_reg_waddr;
    logic [NBITS-1:0]   o_reg_wdata;
    logic [CNTBITS-1:0] o_retired;

    modport master (
        output i_valid, i_regwrite, i_waddr, i_sel_regdata, i_aluresult, i_data,
               i_link, i_imm, i_ld_size, i_ld_unsigned, i_byte_off, i_stall,
               i_flush, i_cnt_clr,
        input  o_valid, o_reg_we, o_reg_waddr, o_reg_wdata, o_retired
    );

    modport slave (
        input  i_valid, i_regwrite, i_waddr, i_sel_regdata, i_aluresult, i_data,
               i_link, i_imm, i_ld_size, i_ld_unsigned, i_byte_off, i_stall,
               i_flush, i_cnt_clr,
        output o_valid, o_reg_we, o_reg_waddr, o_reg_wdata, o_retired
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered MIPS writeback stage: latches MEM/WB, extracts sub-word loads,
// selects the write-back source, gates the register-file write and counts retires.
module wb_select_stage #(
    parameter int NBITS   = 32,
    parameter int SELBITS = 2,
    parameter int REGBITS = 5,
    parameter int OFFBITS = $clog2(NBITS / 8),
    parameter int CNTBITS = 32
) (
    input logic             i_clk,
    input logic             i_rst_n,
    wb_select_stage_if.slave bus
);
    logic               valid_q;
    logic               regwrite_q;
    logic [REGBITS-1:0] waddr_q;
    logic [SELBITS-1:0] sel_q;
    logic [NBITS-1:0]   alu_q;
    logic [NBITS-1:0]   data_q;
    logic [NBITS-1:0]   link_q;
    logic [NBITS-1:0]   imm_q;
    logic [1:0]         ldSize_q;
    logic               ldUnsigned_q;
    logic [OFFBITS-1:0] off_q;
    logic [CNTBITS-1:0] retired_q;
    logic [CNTBITS-1:0] retired_d;

    logic [OFFBITS-1:0] halfOff;
    logic [NBITS-1:0]   byteShifted;
    logic [NBITS-1:0]   halfShifted;
    logic               byteSign;
    logic               halfSign;
    logic [NBITS-1:0]   loadData;
    logic [NBITS-1:0]   wdata;
    logic               selLegal;

    // Flush only kills valid/regwrite; the payload fields simply hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            waddr_q      <= '0;
            sel_q        <= '0;
            alu_q        <= '0;
            data_q       <= '0;
            link_q       <= '0;
            imm_q        <= '0;
            ldSize_q     <= '0;
            ldUnsigned_q <= 1'b0;
            off_q        <= '0;
            retired_q    <= '0;
        end else begin
            retired_q <= retired_d;
            if (bus.i_flush) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
            end else if (!bus.i_stall) begin
                valid_q      <= bus.i_valid;
                regwrite_q   <= bus.i_regwrite;
                waddr_q      <= bus.i_waddr;
                sel_q        <= bus.i_sel_regdata;
                alu_q        <= bus.i_aluresult;
                data_q       <= bus.i_data;
                link_q       <= bus.i_link;
                imm_q        <= bus.i_imm;
                ldSize_q     <= bus.i_ld_size;
                ldUnsigned_q <= bus.i_ld_unsigned;
                off_q        <= bus.i_byte_off;
            end
        end
    end

    // An instruction retires when it leaves the stage; a clear always wins.
    always_comb begin
        retired_d = retired_q;
        if (bus.i_cnt_clr) begin
            retired_d = '0;
        end else if (valid_q && !bus.i_stall) begin
            retired_d = retired_q + CNTBITS'(1);
        end
    end

    assign halfOff     = off_q & ~OFFBITS'(1);
    assign byteShifted = data_q >> {off_q, 3'b000};
    assign halfShifted = data_q >> {halfOff, 3'b000};
    assign byteSign    = byteShifted[7] & ~ldUnsigned_q;
    assign halfSign    = halfShifted[15] & ~ldUnsigned_q;

    always_comb begin
        loadData = data_q;
        case (ldSize_q)
            2'b00:   loadData = {{(NBITS - 8){byteSign}}, byteShifted[7:0]};
            2'b01:   loadData = {{(NBITS - 16){halfSign}}, halfShifted[15:0]};
            default: loadData = data_q;
        endcase
    end

    // Select codes beyond IMM only exist for wider select fields.
    generate
        if (SELBITS > 2) begin : gWideSel
            assign selLegal = ~|sel_q[SELBITS-1:2];
        end else begin : gNarrowSel
            assign selLegal = 1'b1;
        end
    endgenerate

    always_comb begin
        wdata = '1;
        case (sel_q)
            SELBITS'(0): wdata = alu_q;
            SELBITS'(1): wdata = loadData;
            SELBITS'(2): wdata = link_q;
            SELBITS'(3): wdata = imm_q;
            default:     wdata = '1;
        endcase
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_reg_we    = valid_q & regwrite_q & (waddr_q != '0) & selLegal;
    assign bus.o_reg_waddr = waddr_q;
    assign bus.o_reg_wdata = wdata;
    assign bus.o_retired   = retired_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// Randomised and directed bench for wb_select_stage, checked every cycle
// against a behavioural model of the writeback rules.
module tb_wb_select_stage;
    localparam int NBITS   = 32;
    localparam int SELBITS = 3;
    localparam int REGBITS = 5;
    localparam int OFFBITS = 2;
    localparam int CNTBITS = 4;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    always #5 i_clk = ~i_clk;

    wb_select_stage_if #(.NBITS(NBITS), .SELBITS(SELBITS), .REGBITS(REGBITS),
                         .OFFBITS(OFFBITS), .CNTBITS(CNTBITS)) bus ();

    wb_select_stage #(.NBITS(NBITS), .SELBITS(SELBITS), .REGBITS(REGBITS),
                      .OFFBITS(OFFBITS), .CNTBITS(CNTBITS)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit          valid;
        bit          regwrite;
        int          waddr;
        int          sel;
        logic [31:0] alu;
        logic [31:0] data;
        logic [31:0] link;
        logic [31:0] imm;
        int          size;
        bit          uns;
        int          off;
    } instT;

    instT mReg;
    int   mRetired;
    int   checks = 0;
    int   errors = 0;
    bit   checkEn = 0;

    function automatic instT mkInst(bit v, bit rw, int wa, int sel, logic [31:0] alu,
                                    logic [31:0] data, logic [31:0] link, logic [31:0] imm,
                                    int size, bit uns, int off);
        instT t;
        t.valid = v; t.regwrite = rw; t.waddr = wa; t.sel = sel;
        t.alu = alu; t.data = data; t.link = link; t.imm = imm;
        t.size = size; t.uns = uns; t.off = off;
        return t;
    endfunction

    function automatic instT currentInputs();
        return mkInst(bus.i_valid, bus.i_regwrite, int'(bus.i_waddr), int'(bus.i_sel_regdata),
                      bus.i_aluresult, bus.i_data, bus.i_link, bus.i_imm,
                      int'(bus.i_ld_size), bus.i_ld_unsigned, int'(bus.i_byte_off));
    endfunction

    // Little-endian lane extraction expressed as plain shifts and masks.
    function automatic logic [31:0] expLoad(instT t);
        logic [31:0] v;
        int hoff;
        if (t.size >= 2) return t.data;
        if (t.size == 0) begin
            v = (t.data >> (8 * t.off)) & 32'hFF;
            if (!t.uns && v >= 32'd128) v = v | 32'hFFFFFF00;
        end else begin
            hoff = t.off - (t.off % 2);
            v = (t.data >> (8 * hoff)) & 32'hFFFF;
            if (!t.uns && v >= 32'd32768) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] expWdata(instT t);
        if (t.sel == 0) return t.alu;
        if (t.sel == 1) return expLoad(t);
        if (t.sel == 2) return t.link;
        if (t.sel == 3) return t.imm;
        return 32'hFFFFFFFF;
    endfunction

    function automatic bit expWe(instT t);
        return t.valid && t.regwrite && (t.waddr != 0) && (t.sel <= 3);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mReg     = mkInst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            mRetired = 0;
        end else begin
            if (bus.i_cnt_clr) mRetired = 0;
            else if (mReg.valid && !bus.i_stall) mRetired = (mRetired + 1) % (1 << CNTBITS);
            if (bus.i_flush) begin
                mReg.valid    = 0;
                mReg.regwrite = 0;
            end else if (!bus.i_stall) begin
                mReg = currentInputs();
            end
        end
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".valid"}, 32'(bus.o_valid), 32'(mReg.valid));
        checkValue({tag, ".we"}, 32'(bus.o_reg_we), 32'(expWe(mReg)));
        checkValue({tag, ".waddr"}, 32'(bus.o_reg_waddr), 32'(mReg.waddr));
        checkValue({tag, ".wdata"}, bus.o_reg_wdata, expWdata(mReg));
        checkValue({tag, ".retired"}, 32'(bus.o_retired), 32'(mRetired));
    endtask

    always @(negedge i_clk) begin
        if (checkEn) checkOutput("model");
    end

    // Drives one cycle's inputs, then lets one rising edge consume them.
    task automatic applyStimulus(input instT t, input bit stall = 0, input bit flush = 0,
                                 input bit clr = 0);
        bus.i_valid       = t.valid;
        bus.i_regwrite    = t.regwrite;
        bus.i_waddr       = t.waddr[REGBITS-1:0];
        bus.i_sel_regdata = t.sel[SELBITS-1:0];
        bus.i_aluresult   = t.alu;
        bus.i_data        = t.data;
        bus.i_link        = t.link;
        bus.i_imm         = t.imm;
        bus.i_ld_size     = t.size[1:0];
        bus.i_ld_unsigned = t.uns;
        bus.i_byte_off    = t.off[OFFBITS-1:0];
        bus.i_stall       = stall;
        bus.i_flush       = flush;
        bus.i_cnt_clr     = clr;
        @(posedge i_clk);
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, ".valid"}, 32'(bus.o_valid), 32'h0);
        checkValue({tag, ".we"}, 32'(bus.o_reg_we), 32'h0);
        checkValue({tag, ".waddr"}, 32'(bus.o_reg_waddr), 32'h0);
        checkValue({tag, ".wdata"}, bus.o_reg_wdata, 32'h0);
        checkValue({tag, ".retired"}, 32'(bus.o_retired), 32'h0);
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        #1;
        checkAllZero("reset");
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
    endtask

    instT idle;
    instT rnd;
    localparam logic [31:0] LD = 32'h80FF7F01;

    initial begin
        idle = mkInst(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.i_valid = 0; bus.i_regwrite = 0; bus.i_waddr = '0; bus.i_sel_regdata = '0;
        bus.i_aluresult = '0; bus.i_data = '0; bus.i_link = '0; bus.i_imm = '0;
        bus.i_ld_size = '0; bus.i_ld_unsigned = 0; bus.i_byte_off = '0;
        bus.i_stall = 0; bus.i_flush = 0; bus.i_cnt_clr = 0;
        doReset();
        checkEn = 1;

        applyStimulus(mkInst(1, 1, 8, 0, 32'h12345678, 0, 0, 0, 2, 0, 0));
        checkValue("alu.we", 32'(bus.o_reg_we), 32'h1);
        checkValue("alu.waddr", 32'(bus.o_reg_waddr), 32'h8);
        checkValue("alu.wdata", bus.o_reg_wdata, 32'h12345678);
        applyStimulus(mkInst(1, 1, 9, 1, 0, LD, 0, 0, 0, 0, 2));
        checkValue("alu.retired", 32'(bus.o_retired), 32'h1);
        checkValue("ldb2s.wdata", bus.o_reg_wdata, 32'hFFFFFFFF);
        checkValue("model.ldb2s", expWdata(mReg), 32'hFFFFFFFF);
        applyStimulus(mkInst(1, 1, 9, 1, 0, LD, 0, 0, 0, 1, 2));
        checkValue("ldb2u.wdata", bus.o_reg_wdata, 32'h000000FF);
        applyStimulus(mkInst(1, 1, 9, 1, 0, LD, 0, 0, 1, 0, 3));
        checkValue("ldh3s.wdata", bus.o_reg_wdata, 32'hFFFF80FF);
        checkValue("model.ldh3s", expWdata(mReg), 32'hFFFF80FF);
        applyStimulus(mkInst(1, 1, 9, 1, 0, LD, 0, 0, 0, 0, 0));
        checkValue("ldb0.wdata", bus.o_reg_wdata, 32'h00000001);
        applyStimulus(mkInst(1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0, 2, 0, 0));
        checkValue("r0.we", 32'(bus.o_reg_we), 32'h0);
        applyStimulus(idle);
        checkValue("r0.retired", 32'(bus.o_retired), 32'h6);

        applyStimulus(mkInst(1, 1, 3, 0, 32'hA5A5A5A5, 0, 0, 0, 2, 0, 0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkInst(1, 1, 4, 0, 32'h5A5A5A5A, 0, 0, 0, 2, 0, 0), 1);
            checkValue("stall.wdata", bus.o_reg_wdata, 32'hA5A5A5A5);
            checkValue("stall.waddr", 32'(bus.o_reg_waddr), 32'h3);
            checkValue("stall.retired", 32'(bus.o_retired), 32'h6);
        end
        applyStimulus(mkInst(1, 1, 4, 0, 32'h5A5A5A5A, 0, 0, 0, 2, 0, 0), 1, 1);
        checkValue("stflush.valid", 32'(bus.o_valid), 32'h0);
        checkValue("stflush.we", 32'(bus.o_reg_we), 32'h0);

        applyStimulus(mkInst(1, 1, 31, 2, 0, 0, 32'h00400010, 0, 0, 0, 1));
        checkValue("link.wdata", bus.o_reg_wdata, 32'h00400010);
        applyStimulus(mkInst(1, 1, 1, 3, 0, 0, 0, 32'hABCD0000, 0, 0, 1));
        checkValue("imm.wdata", bus.o_reg_wdata, 32'hABCD0000);
        applyStimulus(mkInst(1, 1, 1, 5, 32'h1, 0, 0, 0, 0, 0, 0));
        checkValue("badsel.wdata", bus.o_reg_wdata, 32'hFFFFFFFF);
        checkValue("badsel.we", 32'(bus.o_reg_we), 32'h0);

        doReset();
        for (int i = 0; i < 17; i++) applyStimulus(mkInst(1, 0, i, 0, 32'(i), 0, 0, 0, 2, 0, 0));
        applyStimulus(idle);
        checkValue("wrap.retired", 32'(bus.o_retired), 32'h1);
        applyStimulus(mkInst(1, 1, 2, 0, 32'h77, 0, 0, 0, 2, 0, 0));
        applyStimulus(idle, 0, 0, 1);
        checkValue("clrret.retired", 32'(bus.o_retired), 32'h0);

        applyStimulus(mkInst(1, 1, 7, 0, 32'hCAFEF00D, 0, 0, 0, 2, 0, 0));
        applyStimulus(mkInst(1, 1, 6, 0, 32'h0BADF00D, 0, 0, 0, 2, 0, 0));
        doReset();

        for (int i = 0; i < 400; i++) begin
            rnd = mkInst($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31),
                         ($urandom_range(0, 3) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                         $urandom, $urandom, $urandom, $urandom,
                         $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3));
            applyStimulus(rnd, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 15) == 0);
            if (i == 200) doReset();
        end

        checkEn = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
